// File: rtl/x_serializer_if.sv
// x_serializer_if: word handshake and serial framing bundle between producer and serializer
interface x_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] load_data;
  logic load_valid;
  logic load_ready;
  logic x;
  logic x_valid;
  logic last;
  logic [4:0] bit_idx;
  logic busy;
  logic [15:0] words_sent;
  modport master (
    output load_data, load_valid,
    input  load_ready, x, x_valid, last, bit_idx, busy, words_sent
  );
  modport slave (
    input  load_data, load_valid,
    output load_ready, x, x_valid, last, bit_idx, busy, words_sent
  );
endinterface

// File: rtl/x_serializer.sv
// x_serializer: shifts WIDTH-bit words out on x one bit per clock with word framing and optional gaps
module x_serializer #(
  parameter int WIDTH = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter int GAP = 0,
  parameter bit IDLE_VAL = 1'b0
) (
  input logic clk,
  input logic reset,
  x_serializer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, PAUSE} state_t;
  localparam logic [4:0] LAST_IDX = 5'(WIDTH - 1);
  state_t state;
  logic [WIDTH-1:0] sr;
  logic [3:0] gap_cnt;
  logic word_end, gap_end, accept;
  assign word_end = state == SHIFT && bus.last;
  assign gap_end = state == PAUSE && gap_cnt == 4'(GAP - 1);
  assign bus.load_ready = !reset && (state == IDLE || (word_end && GAP == 0) || gap_end);
  assign accept = bus.load_valid && bus.load_ready;
  assign bus.busy = state != IDLE;
  // sr holds the not-yet-presented bits; the bit on x is already removed from it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      sr <= '0;
      gap_cnt <= '0;
      bus.x <= IDLE_VAL;
      bus.x_valid <= 1'b0;
      bus.last <= 1'b0;
      bus.bit_idx <= '0;
      bus.words_sent <= '0;
    end else begin
      if (word_end) bus.words_sent <= bus.words_sent + 16'd1;
      if (accept) begin
        state <= SHIFT;
        bus.x <= LSB_FIRST ? bus.load_data[0] : bus.load_data[WIDTH-1];
        sr <= LSB_FIRST ? bus.load_data >> 1 : bus.load_data << 1;
        bus.x_valid <= 1'b1;
        bus.last <= 1'b0;
        bus.bit_idx <= '0;
      end else if (state == SHIFT && !bus.last) begin
        bus.x <= LSB_FIRST ? sr[0] : sr[WIDTH-1];
        sr <= LSB_FIRST ? sr >> 1 : sr << 1;
        bus.bit_idx <= bus.bit_idx + 5'd1;
        bus.last <= bus.bit_idx == LAST_IDX - 5'd1;
      end else if (word_end) begin
        state <= GAP > 0 ? PAUSE : IDLE;
        gap_cnt <= '0;
        bus.x <= IDLE_VAL;
        bus.x_valid <= 1'b0;
        bus.last <= 1'b0;
        bus.bit_idx <= '0;
      end else if (state == PAUSE) begin
        state <= gap_end ? IDLE : PAUSE;
        gap_cnt <= gap_cnt + 4'd1;
      end
    end
endmodule
